// File: rtl/modos_multicanal.sv
// Multichannel need levels: timed decay, hold-to-refill, aggregate status.
// Each channel decays on a timer and refills when its request is held.
module modos_multicanal #(
    parameter int N_CH        = 4,
    parameter int LEVEL_W     = 2,
    parameter int DECAY_TICKS = 1250000000,
    parameter int DECAY_TEST  = 50000000,
    parameter int HOLD_TICKS  = 250000000,
    parameter int CNT_W       = 31,
    parameter int REARM       = 1,
    parameter int IDX_W       = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     test,
    input  logic [N_CH-1:0]          entrada,
    input  logic [N_CH-1:0]          activo,
    output logic [N_CH*LEVEL_W-1:0]  nivel,
    output logic [N_CH-1:0]          senal_hold,
    output logic [LEVEL_W-1:0]       min_nivel,
    output logic [IDX_W-1:0]         min_idx,
    output logic                     critico,
    output logic                     todos_max
);

    typedef enum logic [1:0] {IDLE, HOLD, WAIT_REL} state_t;

    localparam logic [LEVEL_W-1:0] MAX    = '1;
    localparam logic [LEVEL_W-1:0] L_ONE  = LEVEL_W'(1);
    localparam logic [CNT_W-1:0]   C_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]   T_NORM = CNT_W'(DECAY_TICKS - 1);
    localparam logic [CNT_W-1:0]   T_FAST = CNT_W'(DECAY_TEST - 1);
    localparam logic [CNT_W-1:0]   H_LAST = CNT_W'(HOLD_TICKS - 1);

    state_t               st_q   [N_CH];
    state_t               st_d   [N_CH];
    logic [CNT_W-1:0]     dcnt_q [N_CH];
    logic [CNT_W-1:0]     dcnt_d [N_CH];
    logic [CNT_W-1:0]     hcnt_q [N_CH];
    logic [CNT_W-1:0]     hcnt_d [N_CH];
    logic [LEVEL_W-1:0]   lvl_q  [N_CH];
    logic [LEVEL_W-1:0]   lvl_d  [N_CH];
    logic [N_CH-1:0]      hold_d;
    logic [N_CH-1:0]      qual;
    logic [CNT_W-1:0]     term;

    logic [LEVEL_W-1:0]   a_min;
    logic [IDX_W-1:0]     a_idx;
    logic                 a_crit;
    logic                 a_full;

    assign qual = entrada & activo;
    assign term = test ? T_FAST : T_NORM;

    // Per-channel decay timer and refill FSM; a refill step overrides decay.
    always_comb begin
        hold_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            st_d[i]   = st_q[i];
            dcnt_d[i] = dcnt_q[i] + C_ONE;
            hcnt_d[i] = hcnt_q[i];
            lvl_d[i]  = lvl_q[i];
            if (dcnt_q[i] >= term) begin
                dcnt_d[i] = '0;
                if (lvl_q[i] != '0) lvl_d[i] = lvl_q[i] - L_ONE;
            end
            unique case (st_q[i])
                IDLE: begin
                    if (qual[i]) begin
                        st_d[i]   = HOLD;
                        hcnt_d[i] = C_ONE;
                    end else begin
                        hcnt_d[i] = '0;
                    end
                end
                HOLD: begin
                    if (!qual[i]) begin
                        st_d[i]   = IDLE;
                        hcnt_d[i] = '0;
                    end else if (hcnt_q[i] == H_LAST) begin
                        hold_d[i] = 1'b1;
                        lvl_d[i]  = (lvl_q[i] == MAX) ? MAX : lvl_q[i] + L_ONE;
                        dcnt_d[i] = '0;
                        hcnt_d[i] = '0;
                        st_d[i]   = (REARM != 0) ? WAIT_REL : HOLD;
                    end else begin
                        hcnt_d[i] = hcnt_q[i] + C_ONE;
                    end
                end
                WAIT_REL: begin
                    hcnt_d[i] = '0;
                    if (!entrada[i]) st_d[i] = IDLE;
                end
                default: begin
                    st_d[i]   = IDLE;
                    hcnt_d[i] = '0;
                end
            endcase
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_CH; i++) begin
                st_q[i]   <= IDLE;
                dcnt_q[i] <= '0;
                hcnt_q[i] <= '0;
                lvl_q[i]  <= MAX;
            end
            senal_hold <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                st_q[i]   <= st_d[i];
                dcnt_q[i] <= dcnt_d[i];
                hcnt_q[i] <= hcnt_d[i];
                lvl_q[i]  <= lvl_d[i];
            end
            senal_hold <= hold_d;
        end
    end

    // Linear min scan; strict less-than keeps the lowest index on ties.
    always_comb begin
        a_min  = lvl_q[0];
        a_idx  = '0;
        a_crit = 1'b0;
        a_full = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            if (lvl_q[i] < a_min) begin
                a_min = lvl_q[i];
                a_idx = IDX_W'(i);
            end
            if (lvl_q[i] == '0) a_crit = 1'b1;
            if (lvl_q[i] != MAX) a_full = 1'b0;
        end
    end

    // Aggregate status registers, one cycle behind the levels.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            min_nivel <= MAX;
            min_idx   <= '0;
            critico   <= 1'b0;
            todos_max <= 1'b1;
        end else begin
            min_nivel <= a_min;
            min_idx   <= a_idx;
            critico   <= a_crit;
            todos_max <= a_full;
        end
    end

    // Flatten the level array onto the output bus.
    always_comb begin
        nivel = '0;
        for (int i = 0; i < N_CH; i++) begin
            nivel[i*LEVEL_W +: LEVEL_W] = lvl_q[i];
        end
    end

endmodule

// File: tb/tb_modos_multicanal.sv
// Bench for modos_multicanal: directed scenarios plus random traffic
// checked every cycle against a cycle-count model of the need levels.
module tb_modos_multicanal;

    localparam int NCH   = 2;
    localparam int LW    = 2;
    localparam int DT    = 20;
    localparam int DTEST = 4;
    localparam int HT    = 5;
    localparam int CW    = 8;
    localparam int RA    = 1;
    localparam int IW    = 1;
    localparam int MAXL  = 3;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           test = 1'b0;
    logic [NCH-1:0] entrada = '0;
    logic [NCH-1:0] activo = '0;
    logic [NCH*LW-1:0] nivel;
    logic [NCH-1:0] senal_hold;
    logic [LW-1:0]  min_nivel;
    logic [IW-1:0]  min_idx;
    logic           critico;
    logic           todos_max;

    int ncmp = 0;
    int nbad = 0;

    // model: level, cycles since last level event, qualified hold run, armed
    int m_lvl   [NCH];
    int m_age   [NCH];
    int m_held  [NCH];
    bit m_armed [NCH];

    modos_multicanal #(
        .N_CH(NCH), .LEVEL_W(LW), .DECAY_TICKS(DT), .DECAY_TEST(DTEST),
        .HOLD_TICKS(HT), .CNT_W(CW), .REARM(RA), .IDX_W(IW)
    ) dut (
        .clk(clk), .reset(reset), .test(test),
        .entrada(entrada), .activo(activo),
        .nivel(nivel), .senal_hold(senal_hold),
        .min_nivel(min_nivel), .min_idx(min_idx),
        .critico(critico), .todos_max(todos_max)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nbad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_lvl[i]   = MAXL;
            m_age[i]   = 0;
            m_held[i]  = 0;
            m_armed[i] = 1'b1;
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".nivel"}, 32'(nivel), 32'hF);
        chk({tag, ".hold"}, 32'(senal_hold), 0);
        chk({tag, ".min"}, 32'(min_nivel), MAXL);
        chk({tag, ".idx"}, 32'(min_idx), 0);
        chk({tag, ".crit"}, 32'(critico), 0);
        chk({tag, ".full"}, 32'(todos_max), 1);
    endtask

    task automatic step();
        int old [NCH];
        int tlim;
        int e_min;
        int e_idx;
        int e_niv;
        int e_pul;
        bit e_crit;
        bit e_full;
        @(posedge clk);
        tlim  = test ? DTEST : DT;
        e_niv = 0;
        e_pul = 0;
        for (int i = 0; i < NCH; i++) old[i] = m_lvl[i];
        for (int i = 0; i < NCH; i++) begin
            bit refill;
            refill = 1'b0;
            if (!m_armed[i]) begin
                if (!entrada[i]) m_armed[i] = 1'b1;
                m_held[i] = 0;
            end else if (entrada[i] && activo[i]) begin
                m_held[i]++;
                if (m_held[i] == HT) refill = 1'b1;
            end else begin
                m_held[i] = 0;
            end
            if (refill) begin
                if (m_lvl[i] < MAXL) m_lvl[i]++;
                m_age[i]   = 0;
                m_held[i]  = 0;
                m_armed[i] = (RA == 0);
                e_pul += (1 << i);
            end else if (m_age[i] + 1 >= tlim) begin
                m_age[i] = 0;
                if (m_lvl[i] > 0) m_lvl[i]--;
            end else begin
                m_age[i]++;
            end
            e_niv += m_lvl[i] << (i * LW);
        end
        e_min  = old[0];
        e_idx  = 0;
        e_crit = 1'b0;
        e_full = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (old[i] < e_min) begin
                e_min = old[i];
                e_idx = i;
            end
            if (old[i] == 0) e_crit = 1'b1;
            if (old[i] != MAXL) e_full = 1'b0;
        end
        #1;
        chk("nivel", 32'(nivel), e_niv);
        chk("senal_hold", 32'(senal_hold), e_pul);
        chk("min_nivel", 32'(min_nivel), e_min);
        chk("min_idx", 32'(min_idx), e_idx);
        chk("critico", 32'(critico), 32'(e_crit));
        chk("todos_max", 32'(todos_max), 32'(e_full));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Asynchronous assert between edges, held over one edge, released
    // at a falling edge.
    task automatic async_reset();
        #1;
        reset = 1'b0;
        #1;
        check_reset("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        check_reset("held_rst");
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset("por");
        @(negedge clk);
        reset = 1'b1;

        // free decay down to zero and staying there
        run(100);

        // hold refill with rearm on channel 0
        async_reset();
        run(40);
        entrada = 2'b01;
        activo  = 2'b01;
        run(12);
        entrada = 2'b00;
        run(2);
        entrada = 2'b01;
        run(6);
        entrada = 2'b00;
        activo  = 2'b00;

        // disabled channel never refills
        entrada = 2'b10;
        run(30);
        entrada = 2'b00;

        // test-mode acceleration from reset, then mid-count switch
        async_reset();
        test = 1'b1;
        run(16);
        test = 1'b0;
        async_reset();
        run(11);
        test = 1'b1;
        run(3);
        test = 1'b0;

        // hold terminal coincident with decay terminal
        async_reset();
        run(35);
        entrada = 2'b11;
        activo  = 2'b11;
        run(5);
        entrada = 2'b00;
        run(25);

        // min tracking, then reset in the middle of a hold
        async_reset();
        run(40);
        entrada = 2'b10;
        activo  = 2'b10;
        run(25);
        entrada = 2'b11;
        activo  = 2'b11;
        run(3);
        async_reset();
        entrada = 2'b00;
        activo  = 2'b00;
        run(3);

        // random traffic
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 7) == 0)
                entrada = entrada ^ 2'($urandom_range(1, 3));
            if ($urandom_range(0, 11) == 0)
                activo = 2'($urandom_range(0, 3)) | 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0)
                test = ~test;
            if ($urandom_range(0, 399) == 0)
                async_reset();
            else
                step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule
